bomb_password_checker: RTL and testbench
========================================

# bomb_password_checker

Consumer side of the password generator: captures the 8-bit password when the generator's result is presented, then runs one game round against it. Keypad entries (two hex digits, high nibble first) are checked against the password under a try limit and a countdown timer. The block drives the defused/exploded outcome plus higher/lower hints and display values to the game's display logic.

## Interface
- MAX_TRIES, default 3: wrong guesses allowed per round; legal range 1..15.
- TIME_LIMIT, default 50_000_000: round length in clk cycles; legal range 1..2^32-1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pw_load  in  1  one-cycle strobe: capture `password` and start a round.
- password  in  8  password value from the generator; sampled only on pw_load.
- key_valid  in  1  one-cycle strobe qualifying key_type/key_digit.
- key_type  in  2  0 = digit, 1 = enter, 2 = clear, 3 = reserved (ignored).
- key_digit  in  4  hex digit; used only when key_type = 0.
- armed  out  1  round in progress.
- defused  out  1  level; correct guess entered.
- exploded  out  1  level; tries exhausted or timer expired.
- guess  out  8  entry register for display.
- digits_entered  out  2  0..2 digits currently held.
- tries_left  out  4  remaining tries.
- hint_high  out  1  last wrong guess was greater than the password.
- hint_low  out  1  last wrong guess was less than the password.
- time_left  out  32  remaining cycles.

## Operation
- States: IDLE, ARMED, DEFUSED, EXPLODED. Outputs armed, defused and exploded are one-hot decodes of ARMED, DEFUSED and EXPLODED.
- Reset state is IDLE. Reset clears every output and internal register to 0, including the captured password, and takes effect at any point, including mid-round.
- pw_load in IDLE, DEFUSED or EXPLODED:
  - captures password;
  - sets tries_left = MAX_TRIES and time_left = TIME_LIMIT;
  - clears guess, digits_entered and both hints;
  - moves to ARMED.
- pw_load in ARMED is ignored.
- key_valid outside ARMED is ignored.
- ARMED, digit key:
  - if digits_entered < 2: guess <= {guess[3:0], key_digit} and digits_entered increments;
  - if digits_entered = 2: the key is ignored.
- ARMED, clear key: guess <= 0 and digits_entered <= 0. Hints are unchanged.
- ARMED, enter key with digits_entered != 2: ignored; no try is consumed.
- ARMED, enter key with digits_entered = 2, unsigned compare of guess with password:
  - equal: move to DEFUSED; guess holds its value; the timer freezes.
  - not equal:
    - tries_left decrements;
    - hint_high = (guess > password) and hint_low = (guess < password);
    - guess and digits_entered clear;
    - if tries_left was 1, move to EXPLODED with tries_left = 0.
- Timer: on every ARMED edge, time_left decrements. An edge that sees time_left = 1 writes time_left <= 0 and moves to EXPLODED.
- Simultaneous events on the same edge:
  - A correct enter while time_left = 1 wins: the state becomes DEFUSED and time_left stays 1.
  - A wrong enter while time_left = 1 gives EXPLODED; hints and tries_left still update.
- In DEFUSED and EXPLODED, all outputs hold until the next pw_load or rst.

## Timing
- Every input effect is registered and visible on outputs the cycle after the sampling edge. There is no combinational input-to-output path.
- pw_load sampled at edge E0: armed = 1 and time_left = TIME_LIMIT after E0.
- With no keys pressed, exploded rises after edge E0+TIME_LIMIT, so armed is high for exactly TIME_LIMIT cycles.
- Key strobes may arrive on back-to-back cycles; each strobe is processed in its own cycle.

## Test plan
- Defuse path (TIME_LIMIT = 20):
  - Stimulus: reset, pw_load with password = 0xA5, then digit A, digit 5, enter.
  - Required: defused = 1 one cycle after enter; tries_left = 3; time_left frozen.
- Wrong guesses:
  - Stimulus: password 0x5A; guesses 0x60, 0x10, 0x77.
  - Required after the first two: hint_high/hint_low = 1/0, then 0/1; tries_left = 2, then 1.
  - Required after the third: exploded = 1, tries_left = 0.
- Entry editing:
  - Stimulus: digits 1, 2, 3.
  - Required: guess = 0x12 and digits_entered = 2 (the third digit is ignored).
  - Stimulus: enter after a single digit. Required: no try consumed.
  - Stimulus: clear. Required: guess = 0, digits_entered = 0.
- Timeout (TIME_LIMIT = 20):
  - Stimulus: pw_load at E0, then idle.
  - Required: exploded rises after E0+20; time_left = 0.
  - Stimulus: keys pressed after the explosion. Required: ignored.
- Timeout race and re-arm:
  - Stimulus: correct enter on the edge where time_left = 1. Required: DEFUSED, not EXPLODED.
  - Stimulus: pw_load while ARMED. Required: ignored.
  - Stimulus: pw_load from DEFUSED. Required: restarts the round with tries_left = 3.
- Reset mid-round:
  - Stimulus: assert rst asynchronously between edges while ARMED with digits_entered = 1.
  - Required: all outputs go to 0 immediately; the state is IDLE.

Source files
------------

// File: rtl/bomb_password_checker_if.sv
// Bundle of the checker's game-facing signals.
//
// Handshake rule: pw_load and key_valid are single-cycle strobes with no
// ready/back-pressure. The checker accepts every strobe on the rising edge
// that samples it, so the sender can strobe on back-to-back cycles. password
// is qualified only by pw_load. key_type and key_digit are qualified only by
// key_valid. Every output is a registered level.
//
// master : generator/keypad/display side (drives strobes, reads status)
// slave  : the checker itself
//
// state exposes the checker FSM encoding for debug and checkers:
// 0 idle, 1 armed, 2 defused, 3 exploded.
interface bomb_password_checker_if;
  logic        pw_load;
  logic [7:0]  password;
  logic        key_valid;
  logic [1:0]  key_type;
  logic [3:0]  key_digit;
  logic        armed;
  logic        defused;
  logic        exploded;
  logic [7:0]  guess;
  logic [1:0]  digits_entered;
  logic [3:0]  tries_left;
  logic        hint_high;
  logic        hint_low;
  logic [31:0] time_left;
  logic [1:0]  state;

  modport master (
    output pw_load, password, key_valid, key_type, key_digit,
    input  armed, defused, exploded, guess, digits_entered, tries_left,
           hint_high, hint_low, time_left, state
  );

  modport slave (
    input  pw_load, password, key_valid, key_type, key_digit,
    output armed, defused, exploded, guess, digits_entered, tries_left,
           hint_high, hint_low, time_left, state
  );
endinterface

// File: rtl/bomb_password_checker.sv
// One game round of the bomb: captures an 8-bit password on pw_load, then
// checks two-digit hex keypad entries against it under a try limit and a
// countdown timer. It reports the defused/exploded outcome, higher/lower
// hints and display values.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset; clears all state to zero / IDLE
//   bus  - slave modport of bomb_password_checker_if. Inputs: pw_load,
//          password, key_valid, key_type, key_digit. Outputs: armed,
//          defused, exploded, guess, digits_entered, tries_left, hint_high,
//          hint_low, time_left, state (debug).
//
// Parameters:
//   MAX_TRIES  - wrong guesses allowed per round (1..15)
//   TIME_LIMIT - round length in clk cycles (1..2^32-1)
module bomb_password_checker #(
  parameter int unsigned MAX_TRIES  = 3,
  parameter logic [31:0] TIME_LIMIT = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  bomb_password_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  localparam logic [1:0] KEY_DIGIT = 2'd0;
  localparam logic [1:0] KEY_ENTER = 2'd1;
  localparam logic [1:0] KEY_CLEAR = 2'd2;

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

  state_t      state_q, state_n;
  logic [7:0]  pw_q, pw_n;
  logic [7:0]  guess_q, guess_n;
  logic [1:0]  digits_q, digits_n;
  logic [3:0]  tries_q, tries_n;
  logic        hh_q, hh_n;
  logic        hl_q, hl_n;
  logic [31:0] time_q, time_n;
  logic        timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pw_q     <= '0;
      guess_q  <= '0;
      digits_q <= '0;
      tries_q  <= '0;
      hh_q     <= 1'b0;
      hl_q     <= 1'b0;
      time_q   <= '0;
    end else begin
      state_q  <= state_n;
      pw_q     <= pw_n;
      guess_q  <= guess_n;
      digits_q <= digits_n;
      tries_q  <= tries_n;
      hh_q     <= hh_n;
      hl_q     <= hl_n;
      time_q   <= time_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    pw_n     = pw_q;
    guess_n  = guess_q;
    digits_n = digits_q;
    tries_n  = tries_q;
    hh_n     = hh_q;
    hl_n     = hl_q;
    time_n   = time_q;
    timeout  = 1'b0;

    case (state_q)
      ARMED: begin
        // The timer runs on every armed edge. A value of 1 means this edge
        // uses up the last cycle. The <= also covers a zero that cannot
        // normally be reached.
        timeout = (time_q <= 32'd1);
        time_n  = timeout ? 32'd0 : time_q - 32'd1;
        if (timeout) state_n = EXPLODED;

        if (bus.key_valid) begin
          case (bus.key_type)
            KEY_DIGIT: begin
              if (digits_q != 2'd2) begin
                guess_n  = {guess_q[3:0], bus.key_digit};
                digits_n = digits_q + 2'd1;
              end
            end
            KEY_CLEAR: begin
              guess_n  = '0;
              digits_n = '0;
            end
            KEY_ENTER: begin
              if (digits_q == 2'd2) begin
                if (guess_q == pw_q) begin
                  // A correct entry beats a simultaneous timeout, and the
                  // timer freezes at its current value.
                  state_n = DEFUSED;
                  time_n  = time_q;
                end else begin
                  tries_n  = tries_q - 4'd1;
                  hh_n     = (guess_q > pw_q);
                  hl_n     = (guess_q < pw_q);
                  guess_n  = '0;
                  digits_n = '0;
                  if (tries_q <= 4'd1) begin
                    state_n = EXPLODED;
                    tries_n = '0;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        // IDLE, DEFUSED and EXPLODED all wait for a new round.
        if (bus.pw_load) begin
          state_n  = ARMED;
          pw_n     = bus.password;
          guess_n  = '0;
          digits_n = '0;
          tries_n  = TRIES_INIT;
          hh_n     = 1'b0;
          hl_n     = 1'b0;
          time_n   = TIME_LIMIT;
        end
      end
    endcase
  end

  assign bus.armed          = (state_q == ARMED);
  assign bus.defused        = (state_q == DEFUSED);
  assign bus.exploded       = (state_q == EXPLODED);
  assign bus.guess          = guess_q;
  assign bus.digits_entered = digits_q;
  assign bus.tries_left     = tries_q;
  assign bus.hint_high      = hh_q;
  assign bus.hint_low       = hl_q;
  assign bus.time_left      = time_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_bomb_password_checker.sv
// Directed bench for bomb_password_checker (MAX_TRIES=3, TIME_LIMIT=20).
// The driver issues keys and loads, then pushes the hand-computed output
// snapshot into exp_q. The monitor pops the snapshot on the next falling
// edge and compares it against the DUT outputs.
module tb_bomb_password_checker;
  localparam int W = 51;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bomb_password_checker_if bus();

  bomb_password_checker #(.MAX_TRIES(3), .TIME_LIMIT(32'd20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           compared   = 0;
  int           mismatched = 0;

  function automatic logic [W-1:0] mk(input logic a, input logic d, input logic x,
                                      input logic [7:0] g, input logic [1:0] n,
                                      input logic [3:0] t, input logic hh,
                                      input logic hl, input logic [31:0] tm);
    return {a, d, x, g, n, t, hh, hl, tm};
  endfunction

  wire [W-1:0] act = {bus.armed, bus.defused, bus.exploded, bus.guess,
                      bus.digits_entered, bus.tries_left, bus.hint_high,
                      bus.hint_low, bus.time_left};

  // Monitor: outputs are sampled away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got a/d/x=%b%b%b guess=%h dig=%0d tries=%0d hh/hl=%b%b time=%0d ; expected a/d/x=%b%b%b guess=%h dig=%0d tries=%0d hh/hl=%b%b time=%0d",
                 nm, act[50], act[49], act[48], act[47:40], act[39:38], act[37:34],
                 act[33], act[32], act[31:0],
                 e[50], e[49], e[48], e[47:40], e[39:38], e[37:34],
                 e[33], e[32], e[31:0]);
      end
    end
  end

  // Every driver task starts and ends at posedge+1 with the strobes low.
  task automatic check(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pw);
    bus.pw_load  = 1'b1;
    bus.password = pw;
    @(posedge clk);
    #1;
    bus.pw_load  = 1'b0;
    bus.password = 8'h00;
  endtask

  task automatic key(input logic [1:0] t, input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_type  = t;
    bus.key_digit = d;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_type  = 2'd0;
    bus.key_digit = 4'd0;
  endtask

  task automatic dig(input logic [3:0] d);
    key(2'd0, d);
  endtask

  task automatic enter();
    key(2'd1, 4'd0);
  endtask

  task automatic clr();
    key(2'd2, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pw_load   = 1'b0;
    bus.password  = 8'h00;
    bus.key_valid = 1'b0;
    bus.key_type  = 2'd0;
    bus.key_digit = 4'd0;

    idle(2);
    check("reset", mk(0,0,0,8'h00,0,0,0,0,0));
    rst = 1'b0;
    idle(1);

    // Defuse path
    load(8'hA5);
    check("arm", mk(1,0,0,8'h00,0,3,0,0,20));
    dig(4'hA);
    check("digit_a", mk(1,0,0,8'h0A,1,3,0,0,19));
    dig(4'h5);
    check("digit_5", mk(1,0,0,8'hA5,2,3,0,0,18));
    enter();
    check("defuse", mk(0,1,0,8'hA5,2,3,0,0,18));
    idle(3);
    check("defuse_frozen", mk(0,1,0,8'hA5,2,3,0,0,18));

    // Wrong guesses
    load(8'h5A);
    check("rearm_from_defused", mk(1,0,0,8'h00,0,3,0,0,20));
    dig(4'h6); dig(4'h0); enter();
    check("wrong_high", mk(1,0,0,8'h00,0,2,1,0,17));
    dig(4'h1); dig(4'h0); enter();
    check("wrong_low", mk(1,0,0,8'h00,0,1,0,1,14));
    dig(4'h7); dig(4'h7); enter();
    check("tries_exhausted", mk(0,0,1,8'h00,0,0,1,0,11));

    // Entry editing
    load(8'h3C);
    dig(4'h1); dig(4'h2); dig(4'h3);
    check("third_digit_ignored", mk(1,0,0,8'h12,2,3,0,0,17));
    clr();
    check("clear", mk(1,0,0,8'h00,0,3,0,0,16));
    dig(4'h4); enter();
    check("short_enter", mk(1,0,0,8'h04,1,3,0,0,14));
    idle(1);

    // Reset mid-round with one digit held
    rst = 1'b1;
    check("async_reset", mk(0,0,0,8'h00,0,0,0,0,0));
    idle(2);
    rst = 1'b0;
    dig(4'h7);
    check("idle_key_ignored", mk(0,0,0,8'h00,0,0,0,0,0));

    // Timeout
    load(8'h99);
    idle(19);
    check("timer_last_cycle", mk(1,0,0,8'h00,0,3,0,0,1));
    idle(1);
    check("timeout", mk(0,0,1,8'h00,0,3,0,0,0));
    dig(4'h9); dig(4'h9); enter(); clr();
    check("keys_after_explode", mk(0,0,1,8'h00,0,3,0,0,0));

    // Timeout race and re-arm
    load(8'hA5);
    load(8'h11);
    check("load_while_armed", mk(1,0,0,8'h00,0,3,0,0,19));
    idle(16);
    dig(4'hA); dig(4'h5); enter();
    check("race_correct_wins", mk(0,1,0,8'hA5,2,3,0,0,1));
    load(8'h22);
    check("rearm_tries", mk(1,0,0,8'h00,0,3,0,0,20));
    idle(17);
    dig(4'h0); dig(4'h1); enter();
    check("race_wrong_explodes", mk(0,0,1,8'h00,0,2,0,1,0));

    idle(3);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending checks, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
